n64_bit_receiver: RTL and testbench

- Parametrised receive front end for the N64 one-wire controller line.
- Decodes pulse-width-coded bits into a parallel word, frames on a stop bit, and flags malformed or stalled traffic.
- Sits between the bidirectional line pad and the response-parsing logic in the N64 test bench.
- Replaces the fixed single-bit receive FSM with width, timing, timeout and error handling.

---
 rtl/n64_bit_receiver.sv | 139 +++++++++++++
 tb/tb_n64_bit_receiver.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/n64_bit_receiver.sv
// Receive front end for the N64 one-wire line: decodes low-pulse widths into bits,
// frames on the stop bit, and flags glitches, stalled lines and aborted frames.
module n64_bit_receiver #(
    parameter int CLKS_PER_US = 12,
    parameter int NUM_BITS    = 32,
    parameter int TIMEOUT_US  = 8
) (
    input  logic                          clk,
    input  logic                          Reset,
    input  logic                          Enable,
    input  logic                          Disable,
    input  logic                          Data_In,
    output logic [NUM_BITS-1:0]           Data_Out,
    output logic                          Valid,
    output logic                          Error,
    output logic                          Busy,
    output logic [$clog2(NUM_BITS+1)-1:0] Bit_Count
);
    localparam int LIMIT = TIMEOUT_US * CLKS_PER_US;
    localparam int TW    = $clog2(LIMIT + 1);
    localparam int CW    = $clog2(NUM_BITS + 1);
    localparam logic [TW-1:0] LIMIT_T  = TW'(LIMIT);
    localparam logic [TW:0]   LIMIT_W  = (TW+1)'(LIMIT);
    localparam logic [TW:0]   TH_W     = (TW+1)'(2 * CLKS_PER_US);
    localparam logic [TW:0]   GL_W     = (TW+1)'(CLKS_PER_US / 2);
    localparam logic [CW-1:0] LAST_BIT = CW'(NUM_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_DONE,
        S_ERR
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_sync1;
    logic                r_sync2;
    logic                r_prev;
    logic [TW-1:0]       r_timer;
    logic [NUM_BITS-1:0] r_shift;
    logic [NUM_BITS-1:0] r_data;
    logic [CW-1:0]       r_count;

    logic                w_fall;
    logic                w_rise;
    logic                w_armed;
    logic [TW:0]         w_width;
    logic                w_bit;
    logic                w_take;

    assign w_fall  = r_prev & ~r_sync2;
    assign w_rise  = ~r_prev & r_sync2;
    assign w_armed = Enable & ~Disable;
    // Width of the current interval counting the present cycle, so an N-cycle
    // pulse at the pin reads as N when its closing edge is seen.
    assign w_width = (TW+1)'(r_timer) + (TW+1)'(1);
    assign w_bit   = (w_width < TH_W);

    always_comb begin
        w_next = r_state;
        w_take = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_armed && w_fall) w_next = S_LOW;
            end
            S_LOW: begin
                if (!w_armed) begin
                    w_next = S_ERR;
                end else if (w_rise) begin
                    if (w_width < GL_W) begin
                        w_next = S_ERR;
                    end else if (r_count == LAST_BIT) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_HIGH;
                        w_take = 1'b1;
                    end
                end else if (w_width >= LIMIT_W) begin
                    w_next = S_ERR;
                end
            end
            S_HIGH: begin
                if (!w_armed) begin
                    w_next = S_ERR;
                end else if (w_fall) begin
                    w_next = S_LOW;
                end else if (w_width >= LIMIT_W) begin
                    w_next = S_ERR;
                end
            end
            S_DONE:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            r_state <= S_IDLE;
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_timer <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            r_sync1 <= Data_In;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (w_fall || w_rise) begin
                r_timer <= '0;
            end else if (r_timer != LIMIT_T) begin
                r_timer <= r_timer + 1'b1;
            end
            if (r_state == S_IDLE && w_next == S_LOW) begin
                r_shift <= '0;
                r_count <= '0;
            end else if (w_take) begin
                r_shift <= (r_shift << 1) | NUM_BITS'(w_bit);
                r_count <= r_count + 1'b1;
            end else if (r_state == S_DONE || r_state == S_ERR) begin
                r_count <= '0;
            end
            // Load on entry to DONE so Data_Out changes in the same cycle Valid pulses.
            if (w_next == S_DONE) r_data <= r_shift;
        end
    end

    assign Data_Out  = r_data;
    assign Valid     = (r_state == S_DONE);
    assign Error     = (r_state == S_ERR);
    assign Busy      = (r_state == S_LOW) || (r_state == S_HIGH);
    assign Bit_Count = r_count;

endmodule

// File: tb/tb_n64_bit_receiver.sv
// Bench for n64_bit_receiver: frames are described as pulse-width lists and the
// expected output timeline is computed from those widths, then checked every cycle.
module tb_n64_bit_receiver;
    localparam int CPU   = 4;
    localparam int NB    = 8;
    localparam int TOUS  = 8;
    localparam int LIMIT = TOUS * CPU;
    localparam int TH    = 2 * CPU;
    localparam int GL    = CPU / 2;
    localparam int MAXC  = 40000;

    logic          clk     = 1'b0;
    logic          Reset   = 1'b0;
    logic          Enable  = 1'b1;
    logic          Disable = 1'b0;
    logic          Data_In = 1'b1;
    logic [NB-1:0] Data_Out;
    logic          Valid;
    logic          Error;
    logic          Busy;
    logic [3:0]    Bit_Count;

    n64_bit_receiver #(.CLKS_PER_US(CPU), .NUM_BITS(NB), .TIMEOUT_US(TOUS)) dut (
        .clk(clk), .Reset(Reset), .Enable(Enable), .Disable(Disable), .Data_In(Data_In),
        .Data_Out(Data_Out), .Valid(Valid), .Error(Error), .Busy(Busy), .Bit_Count(Bit_Count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected output timeline, indexed by cycle number.
    bit         exp_v  [MAXC];
    bit         exp_e  [MAXC];
    bit         exp_b  [MAXC];
    bit         dset   [MAXC];
    logic [7:0] dval   [MAXC];
    int         exp_bc [MAXC];

    int         errors = 0;
    int         checks = 0;
    bit         chk_on = 1'b0;
    logic [7:0] cur_d  = 8'h00;
    int         last_v = -1;
    int         last_e = -1;

    int         lo_q[$];
    int         hi_q[$];
    int         m_end;
    int         m_bits;
    int         m_stop;
    logic [7:0] m_data;
    bit         m_valid;
    int         dec_c[NB];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on && cyc < MAXC) begin
            if (dset[cyc]) cur_d = dval[cyc];
            chk("valid", 64'(Valid), 64'(exp_v[cyc]));
            chk("error", 64'(Error), 64'(exp_e[cyc]));
            chk("busy", 64'(Busy), 64'(exp_b[cyc]));
            chk("data_out", 64'(Data_Out), 64'(cur_d));
            chk("bit_count", 64'(Bit_Count), 64'(exp_bc[cyc]));
            chk("valid_error_excl", 64'(Valid & Error), 64'd0);
            if (Valid) last_v = cyc;
            if (Error) last_e = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Outcome of a frame from its pulse widths; the decoder acts 3 cycles after the pin.
    task automatic model(input int s);
        int t;
        int l;
        int h;
        t = s; m_bits = 0; m_data = 8'h00; m_valid = 1'b0; m_end = -1; m_stop = -1;
        for (int i = 0; i < lo_q.size(); i++) begin
            l = lo_q[i];
            if (l >= LIMIT) begin m_end = t + LIMIT + 3; break; end
            if (l < GL) begin m_end = t + l + 3; break; end
            t += l;
            if (m_bits == NB) begin m_end = t + 3; m_valid = 1'b1; m_stop = t; break; end
            m_data = (m_data << 1) | 8'(l < TH);
            dec_c[m_bits] = t + 3;
            m_bits++;
            h = hi_q[i];
            if (h >= LIMIT) begin m_end = t + LIMIT + 3; break; end
            t += h;
        end
    endtask

    task automatic expect_frame(input int s);
        for (int c = s + 3; c <= m_end; c++) begin
            int n;
            n = 0;
            for (int b = 0; b < m_bits; b++) if (dec_c[b] <= c) n++;
            exp_bc[c] = n;
            exp_b[c]  = (c < m_end);
        end
        if (m_valid) begin
            exp_v[m_end] = 1'b1; dset[m_end] = 1'b1; dval[m_end] = m_data;
        end else begin
            exp_e[m_end] = 1'b1;
        end
    endtask

    // mode: 0 normal, 1 abort via Disable at index k, 2 reset at index k, 3 disarmed
    task automatic run_frame(input int mode, input int k_in, output int s);
        logic w[$];
        int   k;
        int   d;
        for (int i = 0; i < lo_q.size(); i++) begin
            repeat (lo_q[i]) w.push_back(1'b0);
            repeat (hi_q[i]) w.push_back(1'b1);
        end
        s = cyc;
        model(s);
        chk("model_outcome", 64'(m_end >= 0), 64'd1);
        k = -1;
        if (mode == 1 || mode == 2) k = (k_in >= 0) ? k_in : int'($urandom_range(m_end - s - 1, 3));
        d = s + k;
        if (mode != 3 && m_end >= 0) expect_frame(s);
        if (mode == 1) begin
            for (int c = d + 1; c <= m_end; c++) begin
                exp_b[c] = 0; exp_v[c] = 0; exp_e[c] = 0; dset[c] = 0;
                exp_bc[c] = (c == d + 1) ? exp_bc[d] : 0;
            end
            exp_e[d + 1] = 1'b1;
        end
        if (mode == 2) begin
            for (int c = d + 1; c <= m_end; c++) begin
                exp_b[c] = 0; exp_v[c] = 0; exp_e[c] = 0; dset[c] = 0; exp_bc[c] = 0;
            end
            dset[d + 1] = 1'b1; dval[d + 1] = 8'h00;
        end
        if (mode == 3) Enable = 1'b0;
        for (int i = 0; i < w.size(); i++) begin
            if (i == k) begin
                Data_In = 1'b1;
                if (mode == 1) Disable = 1'b1;
                else Reset = 1'b0;
                tick();
                Reset = 1'b1;
                repeat (40) tick();
                Disable = 1'b0;
                repeat (8) tick();
                break;
            end
            Data_In = w[i];
            tick();
        end
        Data_In = 1'b1;
        Enable  = 1'b1;
    endtask

    task automatic clear_frame();
        lo_q.delete();
        hi_q.delete();
    endtask

    task automatic add_bit(input bit b, input int hi_override);
        lo_q.push_back(b ? 4 : 12);
        hi_q.push_back(hi_override > 0 ? hi_override : (b ? 12 : 4));
    endtask

    task automatic add_byte(input logic [7:0] v, input int gap);
        clear_frame();
        for (int i = NB - 1; i >= 0; i--) add_bit(v[i], 0);
        lo_q.push_back(4);
        hi_q.push_back(gap);
    endtask

    // kind: 0 complete frame, 1 glitch somewhere, 2 truncated by a long high
    task automatic build_random(input int kind);
        int g;
        clear_frame();
        for (int i = 0; i < NB; i++) begin
            lo_q.push_back(int'($urandom_range(14, GL)));
            hi_q.push_back(int'($urandom_range(14, 2)));
        end
        lo_q.push_back(int'($urandom_range(12, GL)));
        hi_q.push_back(int'($urandom_range(20, 6)));
        if (kind == 1) begin
            g = int'($urandom_range(NB, 0));
            lo_q[g] = 1;
            hi_q[g] = 12;
            while (lo_q.size() > g + 1) begin void'(lo_q.pop_back()); void'(hi_q.pop_back()); end
        end else if (kind == 2) begin
            g = int'($urandom_range(NB - 1, 0));
            hi_q[g] = LIMIT + 1 + int'($urandom_range(10, 0));
            while (lo_q.size() > g + 1) begin void'(lo_q.pop_back()); void'(hi_q.pop_back()); end
        end
    endtask

    initial begin
        int s;
        int v_before;
        int r;
        tick();
        chk_on = 1'b1;
        tick();
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_valid", 64'(Valid), 64'd0);
        chk("rst_dout", 64'(Data_Out), 64'h00);
        chk("rst_bitcount", 64'(Bit_Count), 64'd0);
        Reset = 1'b1;
        repeat (5) tick();

        // 1,0,1,0,0,1,1,1 then a 4-cycle stop bit
        add_byte(8'hA7, 12);
        run_frame(0, -1, s);
        chk("model_a7_data", 64'(m_data), 64'hA7);
        chk("model_a7_stop", 64'(m_stop - s), 64'd132);
        chk("a7_data_out", 64'(Data_Out), 64'hA7);
        chk("a7_valid_latency", 64'(last_v - s), 64'd135);

        // lows of exactly TH decode as 0, one cycle shorter as 1
        clear_frame();
        for (int i = 0; i < NB; i++) begin
            lo_q.push_back((i % 2 == 0) ? 8 : 7);
            hi_q.push_back(6);
        end
        lo_q.push_back(4); hi_q.push_back(12);
        run_frame(0, -1, s);
        chk("model_th_data", 64'(m_data), 64'h55);
        chk("th_data_out", 64'(Data_Out), 64'h55);

        // three bits then a stalled high line
        clear_frame();
        add_bit(1'b1, 0); add_bit(1'b1, 0); add_bit(1'b1, 44);
        run_frame(0, -1, s);
        chk("timeout_error_cycle", 64'(last_e - s), 64'd71);
        chk("timeout_keeps_data", 64'(Data_Out), 64'h55);
        chk("timeout_busy_after", 64'(Busy), 64'd0);

        // one-cycle glitch, then a good frame
        clear_frame();
        lo_q.push_back(1); hi_q.push_back(12);
        run_frame(0, -1, s);
        chk("glitch_error_cycle", 64'(last_e - s), 64'd4);
        add_byte(8'h5C, 12);
        run_frame(0, -1, s);
        chk("glitch_next_data", 64'(Data_Out), 64'h5C);

        // Disable raised inside bit 5, then a clean all-ones frame
        v_before = last_v;
        add_byte(8'hFF, 12);
        run_frame(1, 66, s);
        chk("abort_error_cycle", 64'(last_e - s), 64'd67);
        chk("abort_no_valid", 64'(last_v), 64'(v_before));
        add_byte(8'hFF, 12);
        run_frame(0, -1, s);
        chk("after_abort_data", 64'(Data_Out), 64'hFF);

        // reset pulse mid-frame
        add_byte(8'h3C, 12);
        run_frame(2, 50, s);
        chk("midreset_dout", 64'(Data_Out), 64'h00);
        chk("midreset_busy", 64'(Busy), 64'd0);
        chk("midreset_bitcount", 64'(Bit_Count), 64'd0);

        // edges ignored while not armed
        v_before = last_v;
        add_byte(8'hA7, 12);
        run_frame(3, -1, s);
        chk("disarmed_no_valid", 64'(last_v), 64'(v_before));
        chk("disarmed_dout", 64'(Data_Out), 64'h00);

        for (int n = 0; n < 60; n++) begin
            if (cyc > MAXC - 500) break;
            r = int'($urandom_range(99, 0));
            if (r < 55)      begin build_random(0); run_frame(0, -1, s); end
            else if (r < 67) begin build_random(1); run_frame(0, -1, s); end
            else if (r < 77) begin build_random(2); run_frame(0, -1, s); end
            else if (r < 87) begin build_random(0); run_frame(1, -1, s); end
            else if (r < 94) begin build_random(0); run_frame(2, -1, s); end
            else             begin build_random(0); run_frame(3, -1, s); end
        end

        repeat (5) tick();
        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
